// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pswseq_4_if.sv
// Power-request / switch-enable bundle between the always-on
// controller and the header-switch sequencer.
interface gf180mcu_fd_sc_mcu9t5v0__pswseq_4_if #(
    parameter int NSW = 4
);
    logic           EN;
    logic [NSW-1:0] SWEN;
    logic           ACK;
    logic           BUSY;

    modport master (
        output EN,
        input  SWEN,
        input  ACK,
        input  BUSY
    );

    modport slave (
        input  EN,
        output SWEN,
        output ACK,
        output BUSY
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pswseq_4.sv
// Power-switch enable sequencer: ramps a thermometer-coded header
// enable one stage every STEP cycles and acks once fully settled.
module gf180mcu_fd_sc_mcu9t5v0__pswseq_4 #(
    parameter int NSW  = 4,
    parameter int STEP = 8
) (
`ifdef USE_POWER_PINS
    inout wire VDD,
    inout wire VSS,
`endif
    input logic CLK,
    input logic RN,
    gf180mcu_fd_sc_mcu9t5v0__pswseq_4_if.slave sw
);
    localparam int CW = (STEP > 1) ? $clog2(STEP) : 1;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        UP   = 2'd1,
        ON   = 2'd2,
        DOWN = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [NSW-1:0] swen, swen_n;
    logic [NSW-1:0] stage_up, stage_dn;
    logic           last, full, empty;

    // Shifting keeps the code thermometer: one bit per stage edge.
    assign stage_up = (swen << 1) | NSW'(1);
    assign stage_dn = swen >> 1;
    assign last     = (cnt == CW'(STEP - 1));
    assign full     = &swen;
    assign empty    = ~|swen;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= OFF;
            cnt   <= '0;
            swen  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            swen  <= swen_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        swen_n  = swen;
        unique case (state)
            OFF: begin
                if (sw.EN) begin
                    state_n = UP;
                    swen_n  = stage_up;
                    cnt_n   = '0;
                end
            end
            UP: begin
                if (!sw.EN) begin
                    state_n = DOWN;
                    swen_n  = stage_dn;
                    cnt_n   = '0;
                end else if (last) begin
                    if (full) state_n = ON;
                    else      swen_n  = stage_up;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ON: begin
                if (!sw.EN) begin
                    state_n = DOWN;
                    swen_n  = stage_dn;
                    cnt_n   = '0;
                end
            end
            DOWN: begin
                if (sw.EN) begin
                    state_n = UP;
                    swen_n  = stage_up;
                    cnt_n   = '0;
                end else if (last) begin
                    if (empty) state_n = OFF;
                    else       swen_n  = stage_dn;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = OFF;
        endcase
    end

    always_comb begin
        sw.SWEN = swen;
        sw.ACK  = (state == ON);
        sw.BUSY = (state == UP) || (state == DOWN);
    end
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__pswseq_4.sv
// Scoreboard bench for the power-switch sequencer: NSW=4/STEP=8
// and NSW=2/STEP=1 instances, plus a thermometer-step watcher.
module tb_gf180mcu_fd_sc_mcu9t5v0__pswseq_4;
    logic CLK = 1'b0;
    logic RN  = 1'b0;

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu9t5v0__pswseq_4_if #(.NSW(4)) ifa ();
    gf180mcu_fd_sc_mcu9t5v0__pswseq_4_if #(.NSW(2)) ifb ();

    gf180mcu_fd_sc_mcu9t5v0__pswseq_4 #(.NSW(4), .STEP(8)) u_a (
        .CLK (CLK),
        .RN  (RN),
        .sw  (ifa.slave)
    );

    gf180mcu_fd_sc_mcu9t5v0__pswseq_4 #(.NSW(2), .STEP(1)) u_b (
        .CLK (CLK),
        .RN  (RN),
        .sw  (ifb.slave)
    );

    typedef struct {
        string      name;
        bit         dut;
        logic [3:0] swen;
        logic       ack;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] therm(int n);
        return 4'((1 << n) - 1);
    endfunction

    function automatic logic okstep(logic [3:0] p, logic [3:0] c);
        return ((c & (c + 4'd1)) == 4'd0) && ($countones(p ^ c) <= 1);
    endfunction

    // Drive one cycle of stimulus; expectation is for after the next edge.
    task automatic cyc(logic ea, logic eb, bit dut, string name,
                       logic [3:0] s, logic a, logic b);
        exp_t e;
        ifa.EN = ea;
        ifb.EN = eb;
        e.name = name;
        e.dut  = dut;
        e.swen = s;
        e.ack  = a;
        e.busy = b;
        q.push_back(e);
        @(negedge CLK);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (!e.dut) begin
                    chk({e.name, ".swen"}, 32'(ifa.SWEN), 32'(e.swen));
                    chk({e.name, ".ack"},  32'(ifa.ACK),  32'(e.ack));
                    chk({e.name, ".busy"}, 32'(ifa.BUSY), 32'(e.busy));
                end else begin
                    chk({e.name, ".swen"}, 32'(ifb.SWEN), 32'(e.swen));
                    chk({e.name, ".ack"},  32'(ifb.ACK),  32'(e.ack));
                    chk({e.name, ".busy"}, 32'(ifb.BUSY), 32'(e.busy));
                end
                chk({e.name, ".ackbusy"},
                    32'(e.dut ? (ifb.ACK & ifb.BUSY) : (ifa.ACK & ifa.BUSY)), 0);
            end
        end
    end

    initial begin : watcher
        logic [3:0] pa, pb;
        pa = '0;
        pb = '0;
        forever begin
            @(posedge CLK or negedge RN);
            if (!RN) begin
                pa = '0;
                pb = '0;
            end else begin
                #1;
                chk("therm_a", 32'(okstep(pa, ifa.SWEN)), 1);
                chk("therm_b", 32'(okstep(pb, {2'b00, ifb.SWEN})), 1);
                pa = ifa.SWEN;
                pb = {2'b00, ifb.SWEN};
            end
        end
    end

    initial begin : stim
        logic en;
        ifa.EN = 1'b0;
        ifb.EN = 1'b0;
        repeat (2) @(negedge CLK);
        cyc(0, 0, 0, "reset_a", 4'h0, 0, 0);
        cyc(0, 0, 1, "reset_b", 4'h0, 0, 0);
        RN = 1'b1;

        for (int j = 0; j < 34; j++)
            cyc(1, 0, 0, "on", (j < 32) ? therm(j / 8 + 1) : 4'hf,
                j >= 32, j < 32);

        for (int j = 0; j < 34; j++)
            cyc(0, 0, 0, "off", (j < 32) ? therm(3 - j / 8) : 4'h0,
                0, j < 32);

        for (int j = 0; j < 28; j++)
            cyc(j < 10, 0, 0, "rev",
                (j < 8) ? 4'h1 : (j < 10) ? 4'h3 : (j < 18) ? 4'h1 : 4'h0,
                0, j < 26);

        for (int j = 0; j < 40; j++) begin
            en = !(j == 28 || j == 29);
            cyc(en, 0, 0, "tail",
                (j < 28) ? therm(j / 8 + 1) : (j < 30) ? 4'h7 : 4'hf,
                j >= 38, j < 38);
        end

        for (int j = 0; j < 34; j++)
            cyc(0, 0, 0, "down", (j < 32) ? therm(3 - j / 8) : 4'h0,
                0, j < 32);

        for (int j = 0; j < 17; j++)
            cyc(1, 0, 0, "ramp", therm(j / 8 + 1), 0, 1);
        #2;
        RN = 1'b0;
        #1;
        chk("async.swen", 32'(ifa.SWEN), 0);
        chk("async.ack",  32'(ifa.ACK),  0);
        chk("async.busy", 32'(ifa.BUSY), 0);
        @(negedge CLK);
        RN = 1'b1;
        for (int j = 0; j < 9; j++)
            cyc(1, 0, 0, "restart", therm(j / 8 + 1), 0, 1);

        for (int j = 0; j < 4; j++)
            cyc(0, 1, 1, "b_on", (j == 0) ? 4'h1 : 4'h3, j >= 2, j < 2);
        for (int j = 0; j < 3; j++)
            cyc(0, 0, 1, "b_off", (j == 0) ? 4'h1 : 4'h0, 0, j < 2);

        @(posedge CLK);
        #3;
        chk("queue_drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
